// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Registered output stage behind the ALU datapath. Captures each ALU result,
// derives its {C,N,Z} flags at capture time and holds it in a 2-entry skid
// buffer. The head entry goes to register-file writeback. When its flag_we
// bit is set, retiring it also updates the persistent status-flag register.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   flush           discard all buffered entries (a retire that cycle completes)
//   in_valid/ready  upstream handshake; in_ready is registered (= !skid valid)
//   in_result       ALU result, BIT_COUNT wide
//   in_carry        adder carry/borrow out (0 for non-arith ops)
//   in_rd           destination register index
//   in_flag_we      entry updates status flags when it retires
//   out_valid/ready writeback handshake on the head entry
//   out_result      head result
//   out_rd          head destination index
//   out_flags       head flags {C,N,Z}
//   status_flags    persistent {C,N,Z}
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int BIT_COUNT  = 8,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIT_COUNT-1:0]  in_result,
    input  logic                  in_carry,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_flag_we,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIT_COUNT-1:0]  out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [2:0]            out_flags,
    output logic [2:0]            status_flags
);

    // Head entry (drives out_*)
    logic                  main_valid_reg;
    logic [BIT_COUNT-1:0]  main_result_reg;
    logic [REG_ADDR_W-1:0] main_rd_reg;
    logic [2:0]            main_flags_reg;
    logic                  main_flag_we_reg;

    // Skid entry, only occupied while the head is stalled
    logic                  skid_valid_reg;
    logic [BIT_COUNT-1:0]  skid_result_reg;
    logic [REG_ADDR_W-1:0] skid_rd_reg;
    logic [2:0]            skid_flags_reg;
    logic                  skid_flag_we_reg;

    logic [2:0]            status_reg;

    logic [2:0] in_flags;
    logic       accept;
    logic       retire;

    // Flags are fixed when the result is captured: {C, N, Z}
    assign in_flags = {in_carry, in_result[BIT_COUNT-1], (in_result == '0)};

    // in_ready depends only on registered state; rst masks it so no
    // transfer can be seen while the stage is held in reset.
    assign in_ready = !skid_valid_reg && !rst;
    assign accept   = in_valid && in_ready;
    assign retire   = main_valid_reg && out_ready;

    assign out_valid    = main_valid_reg;
    assign out_result   = main_result_reg;
    assign out_rd       = main_rd_reg;
    assign out_flags    = main_flags_reg;
    assign status_flags = status_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_reg   <= 1'b0;
            main_result_reg  <= '0;
            main_rd_reg      <= '0;
            main_flags_reg   <= '0;
            main_flag_we_reg <= 1'b0;
            skid_valid_reg   <= 1'b0;
            skid_result_reg  <= '0;
            skid_rd_reg      <= '0;
            skid_flags_reg   <= '0;
            skid_flag_we_reg <= 1'b0;
            status_reg       <= 3'b000;
        end else begin
            // A retire always completes, even in a flush cycle.
            if (retire && main_flag_we_reg) begin
                status_reg <= main_flags_reg;
            end

            if (flush) begin
                main_valid_reg <= 1'b0;
                skid_valid_reg <= 1'b0;
            end else if (retire && skid_valid_reg) begin
                // Skid moves up; accept cannot happen here since in_ready=0.
                main_valid_reg   <= 1'b1;
                main_result_reg  <= skid_result_reg;
                main_rd_reg      <= skid_rd_reg;
                main_flags_reg   <= skid_flags_reg;
                main_flag_we_reg <= skid_flag_we_reg;
                skid_valid_reg   <= 1'b0;
            end else if (accept && (!main_valid_reg || retire)) begin
                main_valid_reg   <= 1'b1;
                main_result_reg  <= in_result;
                main_rd_reg      <= in_rd;
                main_flags_reg   <= in_flags;
                main_flag_we_reg <= in_flag_we;
            end else if (accept) begin
                // Head occupied and stalled: park the new entry in the skid.
                skid_valid_reg   <= 1'b1;
                skid_result_reg  <= in_result;
                skid_rd_reg      <= in_rd;
                skid_flags_reg   <= in_flags;
                skid_flag_we_reg <= in_flag_we;
            end else if (retire) begin
                main_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic       in_carry;
    logic [1:0] in_rd;
    logic       in_flag_we;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [1:0] out_rd;
    logic [2:0] out_flags;
    logic [2:0] status_flags;

    alu_result_stage #(.BIT_COUNT(8), .REG_ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_carry(in_carry), .in_rd(in_rd),
        .in_flag_we(in_flag_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_flags(out_flags),
        .status_flags(status_flags)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a depth-2 FIFO ----------------
    typedef struct {
        logic [7:0] res;
        logic [1:0] rd;
        logic [2:0] fl;
        logic       we;
    } ent_t;

    ent_t       mq[$];
    logic [2:0] mstatus = 3'b000;
    bit         started = 0;
    bit         fresh   = 0;

    always @(posedge clk) begin
        ent_t e;
        started = 1;
        if (rst) begin
            mq.delete();
            mstatus = 3'b000;
            fresh   = 1;
        end else begin
            bit acc;
            acc = in_valid && (mq.size() < 2);
            if (mq.size() > 0 && out_ready) begin
                if (mq[0].we) mstatus = mq[0].fl;
                void'(mq.pop_front());
            end
            if (flush) begin
                mq.delete();
            end else if (acc) begin
                e.res = in_result;
                e.rd  = in_rd;
                e.fl  = {in_carry, in_result[7], in_result == 8'h00};
                e.we  = in_flag_we;
                mq.push_back(e);
                fresh = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!rst && mq.size() < 2)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
            if (mq.size() > 0) begin
                chk("out_result", {24'd0, out_result}, {24'd0, mq[0].res});
                chk("out_rd", {30'd0, out_rd}, {30'd0, mq[0].rd});
                chk("out_flags", {29'd0, out_flags}, {29'd0, mq[0].fl});
            end else if (fresh) begin
                chk("payload_after_reset", {19'd0, out_result, out_rd, out_flags}, 32'd0);
            end
            chk("status_flags", {29'd0, status_flags}, {29'd0, mstatus});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [7:0] r, input logic c,
                         input logic [1:0] rd, input logic we,
                         input logic ordy, input logic fl);
        in_valid   = v;
        in_result  = r;
        in_carry   = c;
        in_rd      = rd;
        in_flag_we = we;
        out_ready  = ordy;
        flush      = fl;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [7:0] got[$];

    initial begin
        rst = 1'b1;
        drive(1, 8'h55, 1, 1, 1, 1, 0);

        // 1. Reset with in_valid held high
        cyc();
        mid();
        chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        cyc();
        rst = 1'b0;
        drive(0, 8'h00, 0, 0, 0, 1, 0);
        mid();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_status", {29'd0, status_flags}, 32'd0);

        // 2. Single pass
        cyc();
        drive(1, 8'h80, 0, 2, 1, 1, 0);
        cyc();
        drive(0, 8'h00, 0, 0, 0, 1, 0);
        mid();
        chk("single_result", {24'd0, out_result}, 32'h80);
        chk("single_rd", {30'd0, out_rd}, 32'd2);
        chk("single_flags", {29'd0, out_flags}, 32'b010);
        cyc();
        mid();
        chk("single_status", {29'd0, status_flags}, 32'b010);

        // 3. Zero/carry, then flag_we=0 leaves status alone
        cyc();
        drive(1, 8'h00, 1, 1, 1, 1, 0);
        cyc();
        drive(0, 8'h00, 0, 0, 0, 1, 0);
        mid();
        chk("zc_flags", {29'd0, out_flags}, 32'b101);
        cyc();
        mid();
        chk("zc_status", {29'd0, status_flags}, 32'b101);
        cyc();
        drive(1, 8'h00, 0, 3, 0, 1, 0);
        cyc();
        drive(0, 8'h00, 0, 0, 0, 1, 0);
        cyc();
        mid();
        chk("nowe_status", {29'd0, status_flags}, 32'b101);

        // 4. Backpressure
        cyc();
        drive(1, 8'h11, 0, 1, 0, 0, 0);
        cyc();
        drive(1, 8'h22, 0, 2, 0, 0, 0);
        cyc();
        drive(1, 8'h33, 0, 3, 0, 0, 0);
        mid();
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_head", {24'd0, out_result}, 32'h11);
        cyc();
        mid();
        chk("bp_stall", {31'd0, in_ready}, 32'd0);
        cyc();
        out_ready = 1'b1;
        got.delete();
        for (int k = 0; k < 10; k++) begin
            bit acc;
            mid();
            if (out_valid && out_ready) got.push_back(out_result);
            acc = in_valid && in_ready;
            cyc();
            if (acc) in_valid = 1'b0;
        end
        chk("bp_count", got.size(), 32'd3);
        if (got.size() == 3) begin
            chk("bp_order0", {24'd0, got[0]}, 32'h11);
            chk("bp_order1", {24'd0, got[1]}, 32'h22);
            chk("bp_order2", {24'd0, got[2]}, 32'h33);
        end

        // 5. Streaming 16 back-to-back
        for (int i = 0; i < 16; i++) begin
            drive(1, 8'(i), 0, 2'(i), 0, 1, 0);
            mid();
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (i > 0) begin
                chk("stream_valid", {31'd0, out_valid}, 32'd1);
                chk("stream_value", {24'd0, out_result}, i - 1);
            end
            cyc();
        end
        drive(0, 8'h00, 0, 0, 0, 1, 0);
        mid();
        chk("stream_valid_last", {31'd0, out_valid}, 32'd1);
        chk("stream_value_last", {24'd0, out_result}, 32'h0F);
        cyc();
        cyc();

        // 6a. Flush with both entries full, out_ready=0
        drive(1, 8'hAA, 0, 1, 1, 0, 0);
        cyc();
        drive(1, 8'hBB, 1, 2, 1, 0, 0);
        cyc();
        drive(0, 8'h00, 0, 0, 0, 0, 0);
        mid();
        chk("fl_head", {24'd0, out_result}, 32'hAA);
        chk("fl_full", {31'd0, in_ready}, 32'd0);
        cyc();
        drive(0, 8'h00, 0, 0, 0, 0, 1);
        cyc();
        drive(0, 8'h00, 0, 0, 0, 0, 0);
        mid();
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_status", {29'd0, status_flags}, 32'b101);

        // 6b. Same, out_ready=1 in flush cycle: AA retires, BB and CC lost
        cyc();
        drive(1, 8'hAA, 0, 1, 1, 0, 0);
        cyc();
        drive(1, 8'hBB, 1, 2, 1, 0, 0);
        cyc();
        drive(1, 8'hCC, 0, 3, 1, 1, 1);
        cyc();
        drive(0, 8'h00, 0, 0, 0, 1, 0);
        mid();
        chk("flr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flr_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flr_status", {29'd0, status_flags}, 32'b010);
        cyc();

        // 7. Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            case ($urandom_range(0, 7))
                0: r = 8'h00;
                1: r = 8'h80;
                default: r = 8'($urandom);
            endcase
            drive(($urandom_range(0, 3) != 0), r, 1'($urandom), 2'($urandom),
                  1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 40) == 0));
            rst = ($urandom_range(0, 600) == 0);
            cyc();
        end
        rst = 1'b0;
        drive(0, 8'h00, 0, 0, 0, 1, 0);
        cyc();
        cyc();
        mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
